// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm controllers. The single-zone alarm FSM
// also imports this package, so the state encoding must stay fixed.
//   alarm_state_e : 3-bit state code (IDLE/ARMED/ENTRY/ALARM/SILENCED)
//   max_int       : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_ARMED    = 3'b001,
        S_ENTRY    = 3'b010,
        S_ALARM    = 3'b011,
        S_SILENCED = 3'b100
    } alarm_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/zone_rr_arb.sv
// -----------------------------------------------------------------------------
// zone_rr_arb
// Combinational round-robin zone picker. The search starts at ptr+1 (mod
// NZONES) and wraps, so the zone granted last time gets the lowest priority.
// The parent module holds the pointer.
// Ports:
//   req   in  [NZONES-1:0]          tripped-zone request vector
//   ptr   in  [clog2(NZONES)-1:0]   index granted last time
//   grant out [clog2(NZONES)-1:0]   granted zone index (holds ptr if none)
//   valid out                       at least one request was granted
// -----------------------------------------------------------------------------
module zone_rr_arb #(
    parameter int NZONES = 4
) (
    input  logic [NZONES-1:0]         req,
    input  logic [$clog2(NZONES)-1:0] ptr,
    output logic [$clog2(NZONES)-1:0] grant,
    output logic                      valid
);

    localparam int IW = $clog2(NZONES);

    logic [IW-1:0] idx;

    always_comb begin
        grant = ptr;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NZONES; i++) begin
            idx = IW'((int'(ptr) + i) % NZONES);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/zone_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// zone_alarm_ctrl
// Multi-zone intrusion alarm sequencer with round-robin zone attribution.
// Build option: define ZONE_ALARM_ENTRY_DELAY_EN to insert the ENTRY delay
// state between ARMED and ALARM. Without it a trip while ARMED goes straight
// to ALARM and code 010 is treated as an illegal state.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE  000  | disarmed; arm_req accepted only with all zones quiet
// ARMED 001  | watching zones
// ENTRY 010  | entry delay running (ENTRY_CYCLES cycles), siren off
// ALARM 011  | siren on for SIREN_CYCLES cycles
// SILENCE 100| siren timed out; any new trip re-enters ALARM directly
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   arm_req          level request to arm (ignored unless IDLE)
//   disarm_req       level request to disarm (wins over arm_req)
//   zone_in          [NZONES] sensor levels, 1 = tripped
//   siren            registered siren drive
//   state            [3] registered state code
//   zone_id          [clog2(NZONES)] zone that caused the current trip
//   zone_log         [NZONES] zones tripped since the last disarm
//   arm_fail         one-cycle pulse when arming is refused
// -----------------------------------------------------------------------------
module zone_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int NZONES       = 4,
    parameter int ENTRY_CYCLES = 16,
    parameter int SIREN_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arm_req,
    input  logic                      disarm_req,
    input  logic [NZONES-1:0]         zone_in,
    output logic                      siren,
    output logic [2:0]                state,
    output logic [$clog2(NZONES)-1:0] zone_id,
    output logic [NZONES-1:0]         zone_log,
    output logic                      arm_fail
);

    localparam int IW = $clog2(NZONES);
    localparam int CW = $clog2(max_int(ENTRY_CYCLES, SIREN_CYCLES)) + 1;

    alarm_state_e      state_q, state_d;
    logic              siren_q, siren_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     zone_id_q, zone_id_d;
    logic [NZONES-1:0] zone_log_q, zone_log_d;
    logic              arm_fail_q, arm_fail_d;
    logic [IW-1:0]     ptr_q, ptr_d;

    logic [IW-1:0]     grant;
    logic              grant_valid;
    logic [NZONES-1:0] grant_onehot;

    zone_rr_arb #(.NZONES(NZONES)) u_arb (
        .req   (zone_in),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    assign grant_onehot = NZONES'(1) << grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            siren_q    <= 1'b0;
            cnt_q      <= '0;
            zone_id_q  <= '0;
            zone_log_q <= '0;
            arm_fail_q <= 1'b0;
            ptr_q      <= IW'(NZONES - 1);
        end else begin
            state_q    <= state_d;
            siren_q    <= siren_d;
            cnt_q      <= cnt_d;
            zone_id_q  <= zone_id_d;
            zone_log_q <= zone_log_d;
            arm_fail_q <= arm_fail_d;
            ptr_q      <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        siren_d    = siren_q;
        cnt_d      = cnt_q;
        zone_id_d  = zone_id_q;
        zone_log_d = zone_log_q;
        arm_fail_d = 1'b0;
        ptr_d      = ptr_q;

        // Disarm from any active state; zone_id and the RR pointer are kept
        // so the next incident still rotates fairly.
        if (disarm_req && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            siren_d    = 1'b0;
            cnt_d      = '0;
            zone_log_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    siren_d = 1'b0;
                    cnt_d   = '0;
                    if (arm_req && !disarm_req) begin
                        if (|zone_in) arm_fail_d = 1'b1;
                        else          state_d    = S_ARMED;
                    end
                end

                S_ARMED: begin
                    if (grant_valid) begin
                        zone_id_d  = grant;
                        ptr_d      = grant;
                        zone_log_d = zone_log_q | grant_onehot;
                        cnt_d      = '0;
`ifdef ZONE_ALARM_ENTRY_DELAY_EN
                        state_d    = S_ENTRY;
`else
                        state_d    = S_ALARM;
                        siren_d    = 1'b1;
`endif
                    end
                end

`ifdef ZONE_ALARM_ENTRY_DELAY_EN
                S_ENTRY: begin
                    zone_log_d = zone_log_q | zone_in;
                    if (cnt_q == CW'(ENTRY_CYCLES - 1)) begin
                        state_d = S_ALARM;
                        siren_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
`endif

                S_ALARM: begin
                    zone_log_d = zone_log_q | zone_in;
                    if (cnt_q == CW'(SIREN_CYCLES - 1)) begin
                        state_d = S_SILENCED;
                        siren_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end

                S_SILENCED: begin
                    zone_log_d = zone_log_q | zone_in;
                    if (grant_valid) begin
                        state_d   = S_ALARM;
                        siren_d   = 1'b1;
                        cnt_d     = '0;
                        zone_id_d = grant;
                        ptr_d     = grant;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    siren_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign siren    = siren_q;
    assign state    = state_q;
    assign zone_id  = zone_id_q;
    assign zone_log = zone_log_q;
    assign arm_fail = arm_fail_q;

endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zone_alarm_ctrl
// Directed self-checking bench for zone_alarm_ctrl (default parameters).
// Honours ZONE_ALARM_ENTRY_DELAY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_zone_alarm_ctrl;

    logic       clk;
    logic       rst_n;
    logic       arm_req;
    logic       disarm_req;
    logic [3:0] zone_in;
    logic       siren;
    logic [2:0] state;
    logic [1:0] zone_id;
    logic [3:0] zone_log;
    logic       arm_fail;

    int n_checks = 0;
    int n_fail   = 0;

    zone_alarm_ctrl #(.NZONES(4), .ENTRY_CYCLES(16), .SIREN_CYCLES(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm_req    (arm_req),
        .disarm_req (disarm_req),
        .zone_in    (zone_in),
        .siren      (siren),
        .state      (state),
        .zone_id    (zone_id),
        .zone_log   (zone_log),
        .arm_fail   (arm_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // advance n rising edges, sample 1 time unit after the last one
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_arm();
        zone_in = 4'b0000;
        arm_req = 1'b1;
        step(1);
        arm_req = 1'b0;
    endtask

    task automatic do_disarm();
        disarm_req = 1'b1;
        step(1);
        disarm_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm_req = 1'b0; disarm_req = 1'b0; zone_in = 4'b0000;
        #12;
        n_checks++; if (state !== 3'd0)    begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++; if (siren !== 1'b0)    begin n_fail++; $display("FAIL reset_siren got %0b want 0", siren); end
        n_checks++; if (zone_id !== 2'd0)  begin n_fail++; $display("FAIL reset_zone_id got %0d want 0", zone_id); end
        n_checks++; if (zone_log !== 4'd0) begin n_fail++; $display("FAIL reset_zone_log got %b want 0000", zone_log); end
        n_checks++; if (arm_fail !== 1'b0) begin n_fail++; $display("FAIL reset_arm_fail got %0b want 0", arm_fail); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL post_reset_state got %0d want 0", state); end
    endtask

    task automatic test_arm();
        do_arm();
        n_checks++; if (state !== 3'd1)    begin n_fail++; $display("FAIL arm_ok_state got %0d want 1", state); end
        n_checks++; if (arm_fail !== 1'b0) begin n_fail++; $display("FAIL arm_ok_fail got %0b want 0", arm_fail); end
        do_disarm();
        n_checks++; if (state !== 3'd0)    begin n_fail++; $display("FAIL disarm_armed got %0d want 0", state); end
        zone_in = 4'b0100;
        arm_req = 1'b1;
        step(1);
        arm_req = 1'b0;
        n_checks++; if (state !== 3'd0)    begin n_fail++; $display("FAIL arm_refused_state got %0d want 0", state); end
        n_checks++; if (arm_fail !== 1'b1) begin n_fail++; $display("FAIL arm_refused_pulse got %0b want 1", arm_fail); end
        step(1);
        n_checks++; if (arm_fail !== 1'b0) begin n_fail++; $display("FAIL arm_fail_width got %0b want 0", arm_fail); end
        zone_in = 4'b0000;
    endtask

    task automatic test_both_requests();
        zone_in = 4'b0100; arm_req = 1'b1; disarm_req = 1'b1;
        step(1);
        n_checks++; if (arm_fail !== 1'b0) begin n_fail++; $display("FAIL both_req_fail got %0b want 0", arm_fail); end
        zone_in = 4'b0000;
        step(1);
        n_checks++; if (state !== 3'd0)    begin n_fail++; $display("FAIL both_req_state got %0d want 0", state); end
        arm_req = 1'b0; disarm_req = 1'b0;
    endtask

    // pointer is NZONES-1 after reset: 1010 -> zone 1, then from 2 -> zone 3
    task automatic test_round_robin();
        do_arm();
        zone_in = 4'b1010;
        step(1);
        zone_in = 4'b0000;
        n_checks++; if (zone_id !== 2'd1)     begin n_fail++; $display("FAIL rr_first_id got %0d want 1", zone_id); end
        n_checks++; if (zone_log !== 4'b0010) begin n_fail++; $display("FAIL rr_first_log got %b want 0010", zone_log); end
        do_disarm();
        n_checks++; if (zone_id !== 2'd1)     begin n_fail++; $display("FAIL disarm_hold_id got %0d want 1", zone_id); end
        n_checks++; if (zone_log !== 4'b0000) begin n_fail++; $display("FAIL disarm_clear_log got %b want 0000", zone_log); end
        n_checks++; if (siren !== 1'b0)       begin n_fail++; $display("FAIL disarm_siren got %0b want 0", siren); end
        do_arm();
        zone_in = 4'b1010;
        step(1);
        zone_in = 4'b0000;
        n_checks++; if (zone_id !== 2'd3)     begin n_fail++; $display("FAIL rr_second_id got %0d want 3", zone_id); end
        n_checks++; if (zone_log !== 4'b1000) begin n_fail++; $display("FAIL rr_second_log got %b want 1000", zone_log); end
        do_disarm();
    endtask

    // pointer is 3 here: zone 1 trips, full entry/siren/silence cycle,
    // re-trip from SILENCED, then reset in the middle of ALARM
    task automatic test_trip_cycle();
        do_arm();
        zone_in = 4'b0010;
        step(1);
        zone_in = 4'b0000;
        n_checks++; if (zone_id !== 2'd1)     begin n_fail++; $display("FAIL trip_id got %0d want 1", zone_id); end
        n_checks++; if (zone_log !== 4'b0010) begin n_fail++; $display("FAIL trip_log got %b want 0010", zone_log); end
`ifdef ZONE_ALARM_ENTRY_DELAY_EN
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL entry_state got %0d want 2", state); end
        step(15);
        n_checks++; if (siren !== 1'b0 || state !== 3'd2) begin n_fail++; $display("FAIL entry_end siren %0b state %0d want 0 2", siren, state); end
        step(1);
`endif
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL alarm_state got %0d want 3", state); end
        n_checks++; if (siren !== 1'b1) begin n_fail++; $display("FAIL siren_rise got %0b want 1", siren); end
        arm_req = 1'b1;
        step(1);
        arm_req = 1'b0;
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL arm_ignored got %0d want 3", state); end
        step(62);
        n_checks++; if (siren !== 1'b1 || state !== 3'd3) begin n_fail++; $display("FAIL siren_last siren %0b state %0d want 1 3", siren, state); end
        step(1);
        n_checks++; if (siren !== 1'b0)  begin n_fail++; $display("FAIL siren_fall got %0b want 0", siren); end
        n_checks++; if (state !== 3'd4)  begin n_fail++; $display("FAIL silenced_state got %0d want 4", state); end
        zone_in = 4'b0001;
        step(1);
        n_checks++; if (state !== 3'd3)       begin n_fail++; $display("FAIL retrip_state got %0d want 3", state); end
        n_checks++; if (siren !== 1'b1)       begin n_fail++; $display("FAIL retrip_siren got %0b want 1", siren); end
        n_checks++; if (zone_id !== 2'd0)     begin n_fail++; $display("FAIL retrip_id got %0d want 0", zone_id); end
        n_checks++; if (zone_log !== 4'b0011) begin n_fail++; $display("FAIL retrip_log got %b want 0011", zone_log); end
        zone_in = 4'b0100;
        step(1);
        zone_in = 4'b0000;
        n_checks++; if (zone_log !== 4'b0111) begin n_fail++; $display("FAIL accum_log got %b want 0111", zone_log); end
        n_checks++; if (zone_id !== 2'd0)     begin n_fail++; $display("FAIL accum_id_hold got %0d want 0", zone_id); end
        step(3);
        rst_n = 1'b0;
        #1;
        n_checks++; if (siren !== 1'b0)       begin n_fail++; $display("FAIL async_rst_siren got %0b want 0", siren); end
        n_checks++; if (state !== 3'd0)       begin n_fail++; $display("FAIL async_rst_state got %0d want 0", state); end
        n_checks++; if (zone_id !== 2'd0)     begin n_fail++; $display("FAIL async_rst_id got %0d want 0", zone_id); end
        n_checks++; if (zone_log !== 4'b0000) begin n_fail++; $display("FAIL async_rst_log got %b want 0000", zone_log); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        n_checks++; if (state !== 3'd0 || siren !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle state %0d siren %0b want 0 0", state, siren); end
    endtask

    // after reset pointer is 3: zone 2 wins; disarm a few cycles in
    task automatic test_disarm_midway();
        int siren_seen;
        siren_seen = 0;
        do_arm();
        zone_in = 4'b0100;
        step(1);
        zone_in = 4'b0000;
        n_checks++; if (zone_id !== 2'd2) begin n_fail++; $display("FAIL mid_trip_id got %0d want 2", zone_id); end
        for (int i = 0; i < 4; i++) begin
            if (siren === 1'b1) siren_seen++;
            step(1);
        end
        do_disarm();
        n_checks++; if (state !== 3'd0)       begin n_fail++; $display("FAIL mid_disarm_state got %0d want 0", state); end
        n_checks++; if (siren !== 1'b0)       begin n_fail++; $display("FAIL mid_disarm_siren got %0b want 0", siren); end
        n_checks++; if (zone_log !== 4'b0000) begin n_fail++; $display("FAIL mid_disarm_log got %b want 0000", zone_log); end
`ifdef ZONE_ALARM_ENTRY_DELAY_EN
        n_checks++; if (siren_seen !== 0) begin n_fail++; $display("FAIL entry_no_siren got %0d cycles want 0", siren_seen); end
`else
        n_checks++; if (siren_seen !== 4) begin n_fail++; $display("FAIL alarm_siren_cycles got %0d want 4", siren_seen); end
`endif
    endtask

    initial begin
        test_reset();
        test_arm();
        test_both_requests();
        test_round_robin();
        test_trip_cycle();
        test_disarm_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
